unsig_altdiv_iter: RTL and testbench
====================================

# unsig_altdiv_iter

Iterative unsigned restoring divider for the functional-unit library. It is the inverse-direction companion to the unsigned approximate multiply-accumulate unit. It splits an accumulated 16-bit product-sum back into quotient and remainder by an 8-bit operand, one quotient bit per enabled clock. It uses a start/busy/done handshake and an optional approximate mode that truncates the low quotient bits, the same way the MAC approximates its low accumulator bits.

## Interface
Parameters:
- NUMER_W, 16, dividend and quotient width
- DENOM_W, 8, divisor and remainder width
- APPROX_BITS, 3, low quotient bits skipped in approximate mode; legal range 1..NUMER_W-1

Ports:
- Clk  input  1  clock, rising edge
- aclr  input  1  reset, asynchronous, active-high
- clken  input  1  clock enable; when low, all state and outputs hold
- start  input  1  request; sampled only on enabled edges in IDLE or DONE
- dividend  input  NUMER_W  numerator, captured with start
- divisor  input  DENOM_W  denominator, captured with start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when the result becomes valid
- quotient  output  NUMER_W  result; held until the next accepted start
- remainder  output  DENOM_W  result; held until the next accepted start
- div_zero  output  1  the result is from a zero divisor; held with the result

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 and a nonzero divisor: capture the operands, clear the partial remainder (DENOM_W+1 bits), set the iteration counter to N. Next state RUN.
  - N = NUMER_W in exact mode; N = NUMER_W-APPROX_BITS with the macro defined.
- IDLE/DONE with start=1 and divisor=0: next state DONE. Outputs are quotient = all ones, remainder = dividend[DENOM_W-1:0], div_zero = 1.
- RUN step, one per enabled edge:
  - Shift the next dividend bit (MSB first) into the partial remainder.
  - Trial-subtract the divisor. If the result is non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
  - Decrement the counter. When the counter reaches 0, go to DONE and load the outputs.
- DONE lasts one enabled cycle with done=1, then goes to IDLE unless a start is accepted. A start in DONE is legal and is handled as from IDLE.
- start while in RUN is ignored. No queueing.
- busy = 1 exactly in RUN. done = 1 exactly in DONE.
- Outputs update only on the edge that enters DONE. Operand capture does not disturb the previous result until that edge.
- Reset value of every output is 0. aclr in any state forces IDLE and aborts any operation in progress without a done pulse.

## Timing
- Start accepted at enabled edge E0. busy is high from E0.
- Exact mode: iterations occur at E1..E16, done and the result appear after E16. Latency is 16 enabled cycles.
- Approximate mode: latency is 13 enabled cycles.
- Divide by zero: done and the result appear after E0. Latency is 1 cycle; busy stays low.
- Disabled cycles (clken=0) stretch the latency one for one. A done pulse held over clken=0 stays high until the next enabled edge.
- Back-to-back operation: a start in the DONE cycle launches the next divide with no idle gap.

## Configuration
- Macro: UNSIG_ALTDIV_APPROX_EN.
- Undefined: exact division; quotient = floor(dividend/divisor) and remainder = dividend mod divisor.
- Defined:
  - Only the top NUMER_W-APPROX_BITS quotient bits are computed.
  - The low APPROX_BITS quotient bits are forced to 1.
  - remainder = partial remainder after the last executed step, which equals (dividend>>APPROX_BITS) mod divisor.
  - div_zero behaviour is unchanged.

## Structure
- Shared package unsig_alt_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default width constants;
  - the counter-width function clog2(NUMER_W+1).
- One sub-module, unsig_altdiv_step: purely combinational, performing the single shift/trial-subtract/select step. Inputs: partial remainder, incoming bit, divisor. Outputs: next remainder, quotient bit.
- Top level contains the FSM, counter, operand/shift registers and output registers.

## Test plan
- Exact: 1000 / 7 -> quotient 142, remainder 6, div_zero 0; done exactly 16 enabled cycles after start; busy high for 16 cycles.
- Approximate (macro defined): 1000 / 7 -> quotient 143 (17<<3 | 7), remainder 6; done after 13 cycles.
- Corner operands, exact: 65535 / 1 -> 65535 r 0; 65535 / 255 -> 257 r 0; 5 / 9 -> 0 r 5.
- Divide by zero: 0x1234 / 0 -> quotient 0xFFFF, remainder 0x34, div_zero 1; done one cycle after start; busy never high.
- Handshake:
  - start pulsed during RUN is ignored, and the first result is unchanged.
  - start in the DONE cycle launches the second divide immediately.
  - clken low for 5 cycles mid-RUN delays done by exactly 5 cycles.
- Reset: aclr asserted at iteration 8 -> all outputs 0, state IDLE, no done pulse. A fresh start after release gives a correct result.

Source files
------------

// File: rtl/unsig_alt_pkg.sv
// rtl/unsig_alt_pkg.sv - shared state type, default widths and counter sizing for the divider
package unsig_alt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_NUMER_W     = 16;
    localparam int DEF_DENOM_W     = 8;
    localparam int DEF_APPROX_BITS = 3;

    function automatic int cnt_width(input int numer_w);
        return $clog2(numer_w + 1);
    endfunction

endpackage

// File: rtl/unsig_altdiv_step.sv
// rtl/unsig_altdiv_step.sv - one restoring-division step: shift in a bit, trial-subtract, select
module unsig_altdiv_step
    import unsig_alt_pkg::*;
#(
    parameter int DENOM_W = DEF_DENOM_W
) (
    input  logic [DENOM_W:0]   i_rem,
    input  logic               i_bit,
    input  logic [DENOM_W-1:0] i_divisor,
    output logic [DENOM_W:0]   o_rem,
    output logic               o_qbit
);

    logic [DENOM_W+1:0] w_shift;
    logic               w_ge;

    assign w_shift = {i_rem, i_bit};
    assign w_ge    = (w_shift >= {2'b00, i_divisor});
    assign o_qbit  = w_ge;
    // A failed trial leaves the shifted value untouched, which is the restore.
    assign o_rem   = w_ge ? (DENOM_W+1)'(w_shift - {2'b00, i_divisor}) : w_shift[DENOM_W:0];

endmodule

// File: rtl/unsig_altdiv_iter.sv
// rtl/unsig_altdiv_iter.sv - iterative unsigned restoring divider; UNSIG_ALTDIV_APPROX_EN skips low quotient bits
module unsig_altdiv_iter
    import unsig_alt_pkg::*;
#(
    parameter int NUMER_W     = DEF_NUMER_W,
    parameter int DENOM_W     = DEF_DENOM_W,
    parameter int APPROX_BITS = DEF_APPROX_BITS
) (
    input  logic               Clk,
    input  logic               aclr,
    input  logic               clken,
    input  logic               start,
    input  logic [NUMER_W-1:0] dividend,
    input  logic [DENOM_W-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [NUMER_W-1:0] quotient,
    output logic [DENOM_W-1:0] remainder,
    output logic               div_zero
);

    localparam int CNT_W = cnt_width(NUMER_W);
`ifdef UNSIG_ALTDIV_APPROX_EN
    localparam int Q_FILL = APPROX_BITS;
`else
    localparam int Q_FILL = 0;
`endif
    localparam int ITERS = NUMER_W - Q_FILL;
    localparam logic [NUMER_W-1:0] Q_MASK = NUMER_W'((64'd1 << Q_FILL) - 64'd1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUMER_W-1:0] r_num;
    logic [DENOM_W:0]   r_rem;
    logic [DENOM_W-1:0] r_div;

    logic [DENOM_W:0]   w_rem;
    logic               w_qbit;
    logic [NUMER_W-1:0] w_q_next;

    unsig_altdiv_step #(
        .DENOM_W (DENOM_W)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_num[NUMER_W-1]),
        .i_divisor (r_div),
        .o_rem     (w_rem),
        .o_qbit    (w_qbit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign w_q_next = {r_num[NUMER_W-2:0], w_qbit};

    always_ff @(posedge Clk or posedge aclr) begin
        if (aclr) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_num     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (clken) begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start && (divisor != '0)) begin
                        r_num   <= dividend;
                        r_div   <= divisor;
                        r_rem   <= '0;
                        r_cnt   <= CNT_W'(ITERS);
                        r_state <= RUN;
                        busy    <= 1'b1;
                    end else if (start) begin
                        quotient  <= '1;
                        remainder <= dividend[DENOM_W-1:0];
                        div_zero  <= 1'b1;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_rem <= w_rem;
                    r_num <= w_q_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= (w_q_next << Q_FILL) | Q_MASK;
                        remainder <= w_rem[DENOM_W-1:0];
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unsig_altdiv_iter.sv
// tb/tb_unsig_altdiv_iter.sv - scoreboard bench for unsig_altdiv_iter; honours UNSIG_ALTDIV_APPROX_EN
module tb_unsig_altdiv_iter;

`ifdef UNSIG_ALTDIV_APPROX_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 16;
`endif

    logic        Clk = 1'b0;
    logic        aclr = 1'b1;
    logic        clken = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy, done, div_zero;
    logic [15:0] quotient;
    logic [7:0]  remainder;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fails  = 0;
    int en_cycle = 0;
    int last_done = -1;

    unsig_altdiv_iter dut (
        .Clk       (Clk),
        .aclr      (aclr),
        .clken     (clken),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (clken && !aclr) en_cycle <= en_cycle + 1;

    // Scoreboard: every new done pulse pops and checks one expected result.
    always @(negedge Clk) begin
        if (done && en_cycle != last_done) begin
            exp_t e;
            last_done = en_cycle;
            n_checks++;
            if (sb.size() == 0) begin
                n_fails++;
                $display("FAIL sb_unexpected_done got q=%0d r=%0d required no done", quotient, remainder);
            end else begin
                e = sb.pop_front();
                n_checks += 3;
                if (quotient !== e.q) begin
                    n_fails++;
                    $display("FAIL sb_quotient got %0d required %0d", quotient, e.q);
                end
                if (remainder !== e.r) begin
                    n_fails++;
                    $display("FAIL sb_remainder got %0d required %0d", remainder, e.r);
                end
                if (div_zero !== e.dz) begin
                    n_fails++;
                    $display("FAIL sb_div_zero got %0b required %0b", div_zero, e.dz);
                end
                if (en_cycle - e.acc !== e.lat) begin
                    n_fails++;
                    $display("FAIL sb_latency got %0d required %0d", en_cycle - e.acc, e.lat);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit track);
        exp_t e;
        int t;
        start = 1'b1;
        dividend = a;
        divisor = b;
        if (track) begin
            if (b == 0) begin
                e.q = 16'hFFFF; e.r = a[7:0]; e.dz = 1'b1; e.lat = 0;
            end else begin
`ifdef UNSIG_ALTDIV_APPROX_EN
                t = int'(a) >> 3;
                e.q = 16'(((t / int'(b)) << 3) | 7);
                e.r = 8'(t % int'(b));
`else
                t = int'(a);
                e.q = 16'(t / int'(b));
                e.r = 8'(t % int'(b));
`endif
                e.dz = 1'b0; e.lat = LAT;
            end
            e.acc = en_cycle + 1;
            sb.push_back(e);
        end
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks += 5;
        if (busy !== 1'b0)      begin n_fails++; $display("FAIL reset_busy got %b required 0", busy); end
        if (done !== 1'b0)      begin n_fails++; $display("FAIL reset_done got %b required 0", done); end
        if (quotient !== 16'd0) begin n_fails++; $display("FAIL reset_quotient got %0d required 0", quotient); end
        if (remainder !== 8'd0) begin n_fails++; $display("FAIL reset_remainder got %0d required 0", remainder); end
        if (div_zero !== 1'b0)  begin n_fails++; $display("FAIL reset_div_zero got %b required 0", div_zero); end
        @(negedge Clk);
        aclr = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_exact();
        logic [15:0] av[8];
        logic [7:0]  bv[8];
        int bc;
        int k;
        av = '{16'd1000, 16'd65535, 16'd65535, 16'd5, 16'd0, 16'd12345, 16'd40000, 16'd255};
        bv = '{8'd7, 8'd1, 8'd255, 8'd9, 8'd3, 8'd100, 8'd200, 8'd255};
        for (int i = 0; i < 12; i++) begin
            if (i < 8) issue(av[i], bv[i], 1'b1);
            else issue(16'($urandom), 8'($urandom_range(1, 255)), 1'b1);
            bc = 0;
            for (k = 0; k < 40 && !done; k++) begin
                if (busy) bc++;
                @(negedge Clk);
            end
            n_checks += 2;
            if (!done) begin n_fails++; $display("FAIL exact_timeout got no done required done in %0d", LAT); end
            if (bc !== LAT) begin n_fails++; $display("FAIL exact_busy_cycles got %0d required %0d", bc, LAT); end
            @(negedge Clk);
        end
        // Explicit check of the headline case, independent of the model.
        issue(16'd1000, 16'd7 == 16'd7 ? 8'd7 : 8'd7, 1'b1);
        for (k = 0; k < 40 && !done; k++) @(negedge Clk);
        n_checks++;
`ifdef UNSIG_ALTDIV_APPROX_EN
        if (quotient !== 16'd143 || remainder !== 8'd6) begin
            n_fails++; $display("FAIL approx_1000_7 got %0d r %0d required 143 r 6", quotient, remainder);
        end
`else
        if (quotient !== 16'd142 || remainder !== 8'd6) begin
            n_fails++; $display("FAIL exact_1000_7 got %0d r %0d required 142 r 6", quotient, remainder);
        end
`endif
        @(negedge Clk);
    endtask

    task automatic test_div_zero();
        issue(16'h1234, 8'd0, 1'b1);
        n_checks += 5;
        if (done !== 1'b1)           begin n_fails++; $display("FAIL dz_done got %b required 1", done); end
        if (busy !== 1'b0)           begin n_fails++; $display("FAIL dz_busy got %b required 0", busy); end
        if (quotient !== 16'hFFFF)   begin n_fails++; $display("FAIL dz_quotient got %h required ffff", quotient); end
        if (remainder !== 8'h34)     begin n_fails++; $display("FAIL dz_remainder got %h required 34", remainder); end
        if (div_zero !== 1'b1)       begin n_fails++; $display("FAIL dz_flag got %b required 1", div_zero); end
        @(negedge Clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fails++; $display("FAIL dz_after got done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_start_in_run();
        int k;
        issue(16'd1000, 8'd7, 1'b1);
        repeat (4) @(negedge Clk);
        issue(16'd50000, 8'd3, 1'b0);
        for (k = 0; k < 40 && !done; k++) @(negedge Clk);
        n_checks++;
        if (!done) begin n_fails++; $display("FAIL run_start_timeout got no done required done"); end
        repeat (25) @(negedge Clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fails++; $display("FAIL run_start_relaunched got busy=%b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        int k;
        issue(16'd60000, 8'd17, 1'b1);
        for (k = 0; k < 40 && !done; k++) @(negedge Clk);
        n_checks++;
        if (!done) begin n_fails++; $display("FAIL b2b_first_timeout got no done required done"); end
        issue(16'd777, 8'd5, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fails++; $display("FAIL b2b_gap got busy=%b done=%b required 1 0", busy, done);
        end
        for (k = 0; k < 40 && !done; k++) @(negedge Clk);
        issue(16'hABCD, 8'd0, 1'b1);
        issue(16'd999, 8'd33, 1'b1);
        for (k = 0; k < 40 && !done; k++) @(negedge Clk);
        n_checks++;
        if (!done) begin n_fails++; $display("FAIL b2b_last_timeout got no done required done"); end
        @(negedge Clk);
    endtask

    task automatic test_clken();
        int cnt;
        issue(16'd40000, 8'd13, 1'b1);
        cnt = 0;
        while (!done && cnt < 60) begin
            clken = (cnt >= 6 && cnt < 11) ? 1'b0 : 1'b1;
            cnt++;
            @(negedge Clk);
        end
        n_checks++;
        if (cnt !== LAT + 5) begin n_fails++; $display("FAIL clken_latency got %0d required %0d", cnt, LAT + 5); end
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_checks++;
            if (done !== 1'b1) begin n_fails++; $display("FAIL clken_done_hold got %b required 1", done); end
        end
        clken = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (done !== 1'b0) begin n_fails++; $display("FAIL clken_done_release got %b required 0", done); end
    endtask

    task automatic test_abort();
        int k;
        issue(16'd1000, 8'd7, 1'b0);
        repeat (7) @(negedge Clk);
        aclr = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'd0 || remainder !== 8'd0 || div_zero !== 1'b0) begin
            n_fails++;
            $display("FAIL abort_outputs got busy=%b done=%b q=%0d r=%0d dz=%b required all 0",
                     busy, done, quotient, remainder, div_zero);
        end
        @(negedge Clk);
        aclr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fails++; $display("FAIL abort_pulse got done=%b busy=%b required 0 0", done, busy);
            end
        end
        issue(16'd1000, 8'd7, 1'b1);
        for (k = 0; k < 40 && !done; k++) @(negedge Clk);
        n_checks++;
        if (!done) begin n_fails++; $display("FAIL abort_restart_timeout got no done required done"); end
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_exact();
        test_div_zero();
        test_start_in_run();
        test_back_to_back();
        test_clken();
        test_abort();
        repeat (3) @(negedge Clk);
        n_checks++;
        if (sb.size() != 0) begin n_fails++; $display("FAIL sb_leftover got %0d required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
